// File: rtl/square_judge_ctrl.sv
// Sequencer and majority-vote filter behind the square-wave judge.
// Runs ROUND_NUM judge rounds per decision and publishes one filtered result.
module square_judge_ctrl #(
   parameter int          OUT_WIDTH  = 18,
   parameter int          CNT_WIDTH  = 32,
   parameter int          ROUND_NUM  = 4,
   parameter int          ROUND_W    = 3,
   parameter int          VOTE_TH    = 3,
   parameter int          GAP_CYCLES = 16,
   parameter logic [31:0] TIMEOUT    = 32'd8000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   output logic                 judge_start,
   input  logic                 judge_dready,
   input  logic                 judge_is_square,
   input  logic [OUT_WIDTH-1:0] judge_min_edge_width,
   input  logic [OUT_WIDTH-1:0] judge_min_pp_width,
   output logic                 is_square,
   output logic [OUT_WIDTH-1:0] edge_width,
   output logic [OUT_WIDTH-1:0] pp_width,
   output logic                 result_valid,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT - 32'd1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [ROUND_W-1:0]   ROUND_LAST = ROUND_W'(ROUND_NUM - 1);
   localparam logic [ROUND_W-1:0]   VOTE_MIN   = ROUND_W'(VOTE_TH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [ROUND_W-1:0]   round_cnt_q, round_cnt_d;
   logic [ROUND_W-1:0]   vote_cnt_q, vote_cnt_d;
   logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [OUT_WIDTH-1:0] min_ew_q, min_ew_d;
   logic [OUT_WIDTH-1:0] min_pp_q, min_pp_d;

   logic                 start_q, start_d;
   logic                 sq_q, sq_d;
   logic [OUT_WIDTH-1:0] ew_q, ew_d;
   logic [OUT_WIDTH-1:0] pp_q, pp_d;
   logic                 rv_q, rv_d;
   logic                 to_q, to_d;
   logic                 busy_q, busy_d;

   logic                 wait_expired;
   logic                 round_end;

   function automatic logic [OUT_WIDTH-1:0] umin(input logic [OUT_WIDTH-1:0] a,
                                                 input logic [OUT_WIDTH-1:0] b);
      return (b < a) ? b : a;
   endfunction

   assign wait_expired = (wait_cnt_q == TO_LAST);
   assign round_end    = (state_q == S_WAIT) && en && (judge_dready || wait_expired);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         round_cnt_q <= '0;
         vote_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         min_ew_q    <= '1;
         min_pp_q    <= '1;
         start_q     <= 1'b0;
         sq_q        <= 1'b0;
         ew_q        <= '1;
         pp_q        <= '1;
         rv_q        <= 1'b0;
         to_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_cnt_q <= round_cnt_d;
         vote_cnt_q  <= vote_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         min_ew_q    <= min_ew_d;
         min_pp_q    <= min_pp_d;
         start_q     <= start_d;
         sq_q        <= sq_d;
         ew_q        <= ew_d;
         pp_q        <= pp_d;
         rv_q        <= rv_d;
         to_q        <= to_d;
         busy_q      <= busy_d;
      end
   end

   // Dropping en in any active state other than DONE abandons the decision.
   always_comb begin
      state_d     = state_q;
      round_cnt_d = round_cnt_q;
      vote_cnt_d  = vote_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      min_ew_d    = min_ew_q;
      min_pp_d    = min_pp_q;
      case (state_q)
         S_IDLE: begin
            round_cnt_d = '0;
            vote_cnt_d  = '0;
            min_ew_d    = '1;
            min_pp_d    = '1;
            if (en) state_d = S_START;
         end
         S_START: begin
            wait_cnt_d = '0;
            state_d    = en ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (judge_dready) begin
                  vote_cnt_d = vote_cnt_q + {{(ROUND_W-1){1'b0}}, judge_is_square};
                  if (judge_is_square) begin
                     min_ew_d = umin(min_ew_q, judge_min_edge_width);
                     min_pp_d = umin(min_pp_q, judge_min_pp_width);
                  end
               end
               if (round_end) begin
                  gap_cnt_d = '0;
                  if (round_cnt_q == ROUND_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     round_cnt_d = round_cnt_q + 1'b1;
                     state_d     = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (!en)                         state_d   = S_IDLE;
            else if (gap_cnt_q == GAP_LAST)  state_d   = S_START;
            else                             gap_cnt_d = gap_cnt_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_d = (state_q == S_START) && en;
      to_d    = (state_q == S_WAIT) && en && !judge_dready && wait_expired;
      rv_d    = (state_q == S_DONE);
      sq_d    = sq_q;
      ew_d    = ew_q;
      pp_d    = pp_q;
      if (state_q == S_DONE) begin
         sq_d = (vote_cnt_q >= VOTE_MIN);
         ew_d = min_ew_q;
         pp_d = min_pp_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   assign judge_start  = start_q;
   assign is_square    = sq_q;
   assign edge_width   = ew_q;
   assign pp_width     = pp_q;
   assign result_valid = rv_q;
   assign timeout_err  = to_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_square_judge_ctrl.sv
// Directed bench for square_judge_ctrl with a behavioural judge responder.
module tb_square_judge_ctrl;

   localparam int          OW  = 18;
   localparam logic [31:0] TO  = 32'd64;
   localparam int          GAP = 16;
   localparam logic [OW-1:0] ONES = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          judge_start;
   logic          judge_dready;
   logic          judge_is_square;
   logic [OW-1:0] judge_min_edge_width;
   logic [OW-1:0] judge_min_pp_width;
   logic          is_square;
   logic [OW-1:0] edge_width;
   logic [OW-1:0] pp_width;
   logic          result_valid;
   logic          timeout_err;
   logic          busy;

   square_judge_ctrl #(
      .OUT_WIDTH (OW),
      .TIMEOUT   (TO),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .en                  (en),
      .judge_start         (judge_start),
      .judge_dready        (judge_dready),
      .judge_is_square     (judge_is_square),
      .judge_min_edge_width(judge_min_edge_width),
      .judge_min_pp_width  (judge_min_pp_width),
      .is_square           (is_square),
      .edge_width          (edge_width),
      .pp_width            (pp_width),
      .result_valid        (result_valid),
      .timeout_err         (timeout_err),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Cycle counter and pulse monitor
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_start = 0, n_rv = 0, n_to = 0, wide_start = 0, wide_rv = 0, last_start = 0;
   logic prev_start = 1'b0, prev_rv = 1'b0;
   int start_q[$];
   int rdy_q[$];
   int to_lat_q[$];

   always @(negedge clk) begin
      prev_start <= judge_start;
      prev_rv    <= result_valid;
      if (judge_start) begin
         n_start    <= n_start + 1;
         last_start <= cyc;
         start_q.push_back(cyc);
      end
      if (judge_start && prev_start)   wide_start <= wide_start + 1;
      if (result_valid && prev_rv)     wide_rv <= wide_rv + 1;
      if (result_valid)                n_rv <= n_rv + 1;
      if (judge_dready)                rdy_q.push_back(cyc);
      if (timeout_err) begin
         n_to <= n_to + 1;
         to_lat_q.push_back(cyc - last_start);
      end
   end

   // Judge responder: answers round k dly_t[k] cycles after its start (0 = never)
   logic          sq_t[4];
   logic [OW-1:0] ew_t[4];
   logic [OW-1:0] pp_t[4];
   int            dly_t[4];
   int            rcnt  = 0;
   int            rbase = 0;

   initial begin
      int idx;
      judge_dready         = 1'b0;
      judge_is_square      = 1'b1;
      judge_min_edge_width = 18'd1;
      judge_min_pp_width   = 18'd1;
      forever begin
         @(posedge clk);
         #1;
         if (judge_start) begin
            idx  = rcnt - rbase;
            rcnt <= rcnt + 1;
            if (idx >= 0 && idx < 4 && dly_t[idx] != 0) begin
               repeat (dly_t[idx] - 1) @(posedge clk);
               #1;
               judge_dready         = 1'b1;
               judge_is_square      = sq_t[idx];
               judge_min_edge_width = ew_t[idx];
               judge_min_pp_width   = pp_t[idx];
               @(posedge clk);
               #1;
               judge_dready         = 1'b0;
               judge_is_square      = 1'b1;
               judge_min_edge_width = 18'd1;
               judge_min_pp_width   = 18'd1;
            end
         end
      end
   end

   task automatic wait_result(input string tag, input int budget);
      int k;
      k = 0;
      while (!result_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_rv_seen"}, result_valid, 1);
   endtask

   task automatic run_decision(input string tag);
      @(negedge clk);
      rbase = rcnt;
      en    = 1'b1;
      wait_result(tag, 3000);
      en = 1'b0;
      @(negedge clk);
      check({tag, "_rv_width"}, result_valid, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exhausted, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   int s0, r0, t0, d0, ws0, wr0, k;

   initial begin
      en    = 1'b0;
      rst   = 1'b1;
      dly_t = '{0, 0, 0, 0};
      sq_t  = '{1'b0, 1'b0, 1'b0, 1'b0};
      ew_t  = '{18'd0, 18'd0, 18'd0, 18'd0};
      pp_t  = '{18'd0, 18'd0, 18'd0, 18'd0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_start", judge_start, 0);
      check("rst_sq", is_square, 0);
      check("rst_ew", edge_width, ONES);
      check("rst_pp", pp_width, ONES);
      check("rst_rv", result_valid, 0);
      check("rst_to", timeout_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // All-square decision with start-pulse timing
      sq_t  = '{1'b1, 1'b1, 1'b1, 1'b1};
      ew_t  = '{18'd100, 18'd80, 18'd120, 18'd90};
      pp_t  = '{18'd200, 18'd170, 18'd240, 18'd180};
      dly_t = '{5, 7, 3, 9};
      s0 = n_start; r0 = n_rv; t0 = n_to; ws0 = wide_start; wr0 = wide_rv;
      rbase = rcnt;
      en = 1'b1;
      @(negedge clk);
      check("t1_start_e0", judge_start, 0);
      check("t1_busy_e0", busy, 1);
      @(negedge clk);
      check("t1_start_e1", judge_start, 1);
      @(negedge clk);
      check("t1_start_e2", judge_start, 0);
      wait_result("t1", 3000);
      en = 1'b0;
      @(negedge clk);
      check("t1_rv_width", result_valid, 0);
      repeat (3) @(negedge clk);
      check("t1_starts", n_start - s0, 4);
      check("t1_rv_cnt", n_rv - r0, 1);
      check("t1_to_cnt", n_to - t0, 0);
      check("t1_start_wide", wide_start - ws0, 0);
      check("t1_rv_wide", wide_rv - wr0, 0);
      check("t1_sq", is_square, 1);
      check("t1_ew", edge_width, 80);
      check("t1_pp", pp_width, 170);
      check("t1_busy_idle", busy, 0);

      // Alternating square rounds: vote fails, non-square widths ignored
      sq_t  = '{1'b1, 1'b0, 1'b1, 1'b0};
      ew_t  = '{18'd100, 18'd10, 18'd90, 18'd5};
      pp_t  = '{18'd200, 18'd20, 18'd150, 18'd8};
      dly_t = '{4, 6, 2, 8};
      s0 = n_start; r0 = n_rv;
      run_decision("t2");
      check("t2_starts", n_start - s0, 4);
      check("t2_rv_cnt", n_rv - r0, 1);
      check("t2_sq", is_square, 0);
      check("t2_ew", edge_width, 90);
      check("t2_pp", pp_width, 150);

      // Judge never answers: every round times out
      dly_t = '{0, 0, 0, 0};
      s0 = n_start; t0 = n_to; d0 = to_lat_q.size();
      run_decision("t3");
      check("t3_starts", n_start - s0, 4);
      check("t3_to_cnt", n_to - t0, 4);
      for (int i = 0; i < 4; i++) check("t3_to_latency", to_lat_q[d0 + i], TO);
      check("t3_sq", is_square, 0);
      check("t3_ew", edge_width, ONES);
      check("t3_pp", pp_width, ONES);

      // dready on the timeout cycle of round 0 still counts
      sq_t  = '{1'b1, 1'b1, 1'b1, 1'b0};
      ew_t  = '{18'd50, 18'd100, 18'd120, 18'd10};
      pp_t  = '{18'd60, 18'd200, 18'd210, 18'd5};
      dly_t = '{int'(TO), 4, 6, 5};
      s0 = start_q.size(); d0 = rdy_q.size(); t0 = n_to;
      run_decision("t4");
      check("t4_starts", start_q.size() - s0, 4);
      check("t4_to_cnt", n_to - t0, 0);
      check("t4_gap", start_q[s0 + 1] - rdy_q[d0], GAP + 2);
      check("t4_sq", is_square, 1);
      check("t4_ew", edge_width, 50);
      check("t4_pp", pp_width, 60);

      // Abort during the gap after round 2, then a fresh decision
      sq_t  = '{1'b1, 1'b1, 1'b1, 1'b1};
      ew_t  = '{18'd1, 18'd1, 18'd1, 18'd1};
      pp_t  = '{18'd1, 18'd1, 18'd1, 18'd1};
      dly_t = '{4, 4, 4, 4};
      s0 = n_start; r0 = n_rv; d0 = rdy_q.size();
      @(negedge clk);
      rbase = rcnt;
      en = 1'b1;
      k = 0;
      while (rdy_q.size() - d0 < 2 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("t5_two_rounds", (rdy_q.size() - d0 >= 2) ? 1 : 0, 1);
      repeat (4) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("t5_busy_abort", busy, 0);
      repeat (60) @(negedge clk);
      check("t5_starts_abort", n_start - s0, 2);
      check("t5_no_rv", n_rv - r0, 0);
      check("t5_hold_sq", is_square, 1);
      check("t5_hold_ew", edge_width, 50);
      check("t5_hold_pp", pp_width, 60);
      sq_t  = '{1'b1, 1'b1, 1'b0, 1'b1};
      ew_t  = '{18'd300, 18'd250, 18'd5, 18'd260};
      pp_t  = '{18'd400, 18'd350, 18'd5, 18'd360};
      dly_t = '{3, 5, 4, 6};
      s0 = n_start; r0 = n_rv;
      run_decision("t5b");
      check("t5b_starts", n_start - s0, 4);
      check("t5b_rv_cnt", n_rv - r0, 1);
      check("t5b_sq", is_square, 1);
      check("t5b_ew", edge_width, 250);
      check("t5b_pp", pp_width, 350);

      // Asynchronous reset in the middle of WAIT
      dly_t = '{0, 0, 0, 0};
      @(negedge clk);
      rbase = rcnt;
      en = 1'b1;
      k = 0;
      while (!judge_start && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t6_start_seen", judge_start, 1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_start", judge_start, 0);
      check("t6_sq", is_square, 0);
      check("t6_ew", edge_width, ONES);
      check("t6_pp", pp_width, ONES);
      check("t6_rv", result_valid, 0);
      check("t6_to", timeout_err, 0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      s0 = n_start; r0 = n_rv; t0 = n_to;
      repeat (100) @(negedge clk);
      check("t6_quiet_start", n_start - s0, 0);
      check("t6_quiet_to", n_to - t0, 0);
      check("t6_quiet_rv", n_rv - r0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
